// File: rtl/mem_access_ctrl_if.sv
// Bus between the processor datapath, mem_access_ctrl and the singleport_ram.
// Handshake: the requester raises req with req_we/req_addr/req_wdata and holds them until it sees
// the one-cycle ack; the controller samples req only while busy=0 and ignores it otherwise.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              ram_write_en;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output req, req_we, req_addr, req_wdata, ram_data_out,
    input  busy, ack, err, rdata, ram_write_en, ram_read_en, ram_addr, ram_data_in
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_data_out,
    output busy, ack, err, rdata, ram_write_en, ram_read_en, ram_addr, ram_data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-word request/ack front end for singleport_ram: issues the RAM enables, waits out the
// read latency, returns rdata with a one-cycle ack and rejects out-of-range addresses with err.
module mem_access_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] RL = 3'(READ_LATENCY);

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_err_pend;
  logic              r_busy;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              r_write_en;
  logic              r_read_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_in;
  logic              w_addr_bad;

  assign w_addr_bad = int'(bus.req_addr) >= DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      r_addr     <= '0;
      r_data_in  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (bus.req) begin
            r_addr    <= bus.req_addr;
            r_data_in <= bus.req_wdata;
            r_busy    <= 1'b1;
            if (w_addr_bad) begin
              r_err_pend <= 1'b1;
              r_state    <= DONE;
            end else if (bus.req_we) begin
              r_write_en <= 1'b1;
              r_state    <= WRITE;
            end else begin
              r_read_en <= 1'b1;
              r_cnt     <= 3'd0;
              r_state   <= READ;
            end
          end
        end
        WRITE: begin
          r_write_en <= 1'b0;
          r_ack      <= 1'b1;
          r_state    <= DONE;
        end
        READ: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == RL) begin
            r_rdata   <= bus.ram_data_out;
            r_ack     <= 1'b1;
            r_read_en <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // A rejected request spends one extra DONE cycle so its ack lands one edge after sampling.
          if (r_err_pend) begin
            r_err_pend <= 1'b0;
            r_ack      <= 1'b1;
            r_err      <= 1'b1;
          end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.ack          = r_ack;
  assign bus.err          = r_err;
  assign bus.rdata        = r_rdata;
  assign bus.ram_write_en = r_write_en;
  assign bus.ram_read_en  = r_read_en;
  assign bus.ram_addr     = r_addr;
  assign bus.ram_data_in  = r_data_in;
  assign o_dbg_state      = r_state;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Request/acknowledge front end that sits directly upstream of singleport_ram.
- Accepts single-word read or write requests from the processor datapath.
- Drives the RAM's write_en, read_en, addr and Data_in, then captures Data_out after the RAM's read latency.
- Returns the result with a one-cycle ack; rejects out-of-range addresses with an err pulse.

Parameters:
- ADDR_W, 9, address width (matches the RAM addr port)
- DATA_W, 16, data width (matches the RAM Data_in/Data_out)
- DEPTH, 512, number of valid words; addresses >= DEPTH are rejected
- READ_LATENCY, 1, cycles from RAM read_en being sampled to Data_out valid; legal range 1..7

Ports:
- clk  in  1  rising-edge clock, shared with singleport_ram
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  access request; sampled only in IDLE
- req_we  in  1  1 = write, 0 = read; sampled with req
- req_addr  in  ADDR_W  word address; sampled with req
- req_wdata  in  DATA_W  write data; sampled with req
- busy  out  1  high in every state except IDLE
- ack  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with ack, for a rejected request
- rdata  out  DATA_W  read result; valid when ack=1 on a read and held until the next read completes
- ram_write_en  out  1  to RAM write_en
- ram_read_en  out  1  to RAM read_en
- ram_addr  out  ADDR_W  to RAM addr
- ram_data_in  out  DATA_W  to RAM Data_in
- ram_data_out  in  DATA_W  from RAM Data_out

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state <= IDLE.
  - Every output, including rdata, ram_addr and ram_data_in, is forced to 0.
  - Reset asserted mid-access aborts the access: no ack, RAM enables drop immediately.
- All outputs are registered. In the timing below, E is the clock edge at which IDLE samples req=1.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - busy=0.
  - On req=1, latch req_we, req_addr and req_wdata; drive ram_addr and ram_data_in from the latched values at E.
  - If req_addr >= DEPTH: go to DONE with err queued. No RAM enable is asserted.
  - Else if req_we=1: go to WRITE and set ram_write_en=1 at E.
  - Else: go to READ, set ram_read_en=1 at E, cnt=0.
- WRITE:
  - The RAM samples the write at E+1.
  - At E+1: ram_write_en <= 0, ack <= 1, go to DONE.
- READ:
  - ram_read_en stays high from E until edge E+1+READ_LATENCY.
  - cnt (3 bits) increments each edge while in READ.
  - When cnt == READ_LATENCY (edge E+1+READ_LATENCY): rdata <= ram_data_out, ack <= 1, ram_read_en <= 0, go to DONE.
- DONE:
  - ack (and err, if queued) is high for exactly this one cycle.
  - Next edge: ack <= 0, err <= 0, go to IDLE.
- Rejected request: ack and err both assert at E+1. rdata and the RAM enables are untouched.
- Throughput:
  - Write: ack visible in the cycle after E+1. The next req can be sampled at E+3 at the earliest.
  - Read: ack visible in the cycle after E+1+READ_LATENCY.
- req while busy=1 is ignored, not queued. The requester holds req until it sees ack, then deasserts it.
  - req still high when the block returns to IDLE is treated as a new request.
- ram_addr and ram_data_in hold their last value between accesses; there is no combinational path from req_* to ram_*.
- ram_write_en and ram_read_en are never high in the same cycle.
- Maximum address: DEPTH-1 (511) is accepted; DEPTH (512) is not representable at ADDR_W=9. With DEPTH<512, addresses DEPTH..511 return err.

Test Plan:
- Write addr=1 data=1: ram_write_en high for exactly 1 cycle with ram_addr=1 and ram_data_in=1. Ack pulses 2 cycles after req is sampled. err=0.
- Write addr=2 data=4, then read addr=1 and read addr=2 (READ_LATENCY=1): each read acks 3 cycles after sampling with rdata=1 and then rdata=4. ram_read_en is high for 2 cycles each time.
- Hold req high continuously across back-to-back accesses: every access completes, busy never drops mid-access, and a second req arriving during busy is not double-executed.
- DEPTH=256, read addr=300: ack=1 and err=1 in the same cycle. ram_read_en and ram_write_en stay 0, and rdata keeps its previous value.
- Assert rst_n=0 while in READ with ram_read_en=1: all outputs go to 0 without waiting for a clock edge. After release, a read of addr=2 returns 4 (RAM contents are preserved).
- READ_LATENCY=3: read addr=2 gives ack 5 cycles after sampling and rdata=4.
